// File: rtl/unibus_pkg.sv
// Shared definitions for the unified-bus memory responder and the fetch side.
package unibus_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RDATA = 2'd2,
        WDATA = 2'd3
    } state_t;

    // Request command encoding on req_write.
    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Value seen on the bus when no agent drives it (only used at the top level).
    localparam logic [7:0] HIGH_IMPEDANCE = 8'hZZ;

    // Data returned for a read of an unimplemented address.
    localparam logic [7:0] UNMAPPED_READ_VALUE = 8'hFF;

    // Idle value of the read-data output.
    localparam logic [7:0] BUS_IDLE_VALUE = 8'h00;

    // True when the 8-bit address falls inside the implemented words.
    function automatic logic addr_in_range(input logic [7:0] addr, input int unsigned depth);
        return (32'(addr) < depth);
    endfunction

endpackage

// File: rtl/unibus_mem_array.sv
// DEPTH x 8 storage: synchronous write, combinational read, never reset.
module unibus_mem_array #(
    parameter int         DEPTH      = 256,
    parameter int         AW         = 8,
    parameter logic [7:0] INIT_VALUE = 8'h00
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    // Start-up content comes from the declaration; reset never touches the array.
    logic [7:0] mem [DEPTH] = '{default: INIT_VALUE};

    // Commit a write at the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read port.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/unibus_memory.sv
// Unified-bus memory responder: one address cycle, then either a write-data
// cycle or optional wait cycles followed by one read-data cycle.
module unibus_memory
    import unibus_pkg::*;
#(
    parameter int         DEPTH       = 256,
    parameter int         WAIT_STATES = 0,
    parameter logic [7:0] INIT_VALUE  = 8'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req_valid,
    input  logic       req_write,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       ready,
    output logic       rd_valid,
    output logic       wr_done,
    output logic       err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Last value the wait counter reaches before moving to RDATA.
    localparam logic [1:0] WS_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] addr_r;
    logic [7:0] addr_s;
    logic       cmd_r;
    logic       cmd_s;
    logic [1:0] wait_cnt_r;
    logic [1:0] wait_cnt_s;

    logic       mem_we_s;
    logic [7:0] rd_addr_s;
    logic [7:0] rd_data_s;

    logic [7:0] bus_out_s;
    logic       bus_oe_s;
    logic       ready_s;
    logic       rd_valid_s;
    logic       wr_done_s;
    logic       err_s;

    unibus_mem_array #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .INIT_VALUE (INIT_VALUE)
    ) u_array (
        .clk   (CLK),
        .we    (mem_we_s),
        .waddr (addr_r[AW-1:0]),
        .wdata (bus_in),
        .raddr (rd_addr_s[AW-1:0]),
        .rdata (rd_data_s)
    );

    // Next-state, request latching and array write enable.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        cmd_s      = cmd_r;
        wait_cnt_s = wait_cnt_r;
        mem_we_s   = 1'b0;
        rd_addr_s  = addr_r;
        case (state_r)
            IDLE: begin
                // Read data for a zero-wait read is looked up from the address on the bus.
                rd_addr_s = bus_in;
                if (req_valid) begin
                    addr_s     = bus_in;
                    cmd_s      = req_write;
                    wait_cnt_s = 2'd0;
                    if (req_write == CMD_WRITE) begin
                        state_s = WDATA;
                    end else if (WAIT_STATES == 0) begin
                        state_s = RDATA;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == WS_LAST) begin
                    state_s = RDATA;
                end else begin
                    wait_cnt_s = wait_cnt_r + 2'd1;
                end
            end
            RDATA: begin
                state_s = IDLE;
            end
            WDATA: begin
                mem_we_s = (cmd_r == CMD_WRITE) && addr_in_range(addr_r, 32'(DEPTH));
                state_s  = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        ready_s    = (state_s == IDLE);
        rd_valid_s = (state_s == RDATA);
        bus_oe_s   = rd_valid_s;
        wr_done_s  = (state_r == WDATA);
        bus_out_s  = BUS_IDLE_VALUE;
        err_s      = 1'b0;
        if (rd_valid_s) begin
            if (addr_in_range(rd_addr_s, 32'(DEPTH))) begin
                bus_out_s = rd_data_s;
            end else begin
                bus_out_s = UNMAPPED_READ_VALUE;
                err_s     = 1'b1;
            end
        end else if (state_r == WDATA) begin
            err_s = !addr_in_range(addr_r, 32'(DEPTH));
        end else begin
            err_s = 1'b0;
        end
    end

    // State, request latches and registered outputs; reset forces IDLE outputs at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= IDLE;
            addr_r     <= 8'h00;
            cmd_r      <= CMD_READ;
            wait_cnt_r <= 2'd0;
            ready      <= 1'b1;
            bus_oe     <= 1'b0;
            bus_out    <= BUS_IDLE_VALUE;
            rd_valid   <= 1'b0;
            wr_done    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_r    <= state_s;
            addr_r     <= addr_s;
            cmd_r      <= cmd_s;
            wait_cnt_r <= wait_cnt_s;
            ready      <= ready_s;
            bus_oe     <= bus_oe_s;
            bus_out    <= bus_out_s;
            rd_valid   <= rd_valid_s;
            wr_done    <= wr_done_s;
            err        <= err_s;
        end
    end

endmodule

// File: tb/tb_unibus_memory.sv
// Directed bench for unibus_memory: two configurations (256 words / no wait,
// 16 words / two wait states) checked every cycle against a transaction model.
module tb_unibus_memory;

    localparam int NC = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       [2];
    logic       req_valid [2];
    logic       req_write [2];
    logic [7:0] bus_in    [2];
    logic [7:0] bus_out   [2];
    logic       bus_oe    [2];
    logic       ready     [2];
    logic       rd_valid  [2];
    logic       wr_done   [2];
    logic       err       [2];

    unibus_memory #(.DEPTH(256), .WAIT_STATES(0), .INIT_VALUE(8'h00)) dut0 (
        .CLK(clk), .RST(rst[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
        .bus_in(bus_in[0]), .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .ready(ready[0]),
        .rd_valid(rd_valid[0]), .wr_done(wr_done[0]), .err(err[0]));

    unibus_memory #(.DEPTH(16), .WAIT_STATES(2), .INIT_VALUE(8'h00)) dut1 (
        .CLK(clk), .RST(rst[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
        .bus_in(bus_in[1]), .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .ready(ready[1]),
        .rd_valid(rd_valid[1]), .wr_done(wr_done[1]), .err(err[1]));

    // Model: expected outputs per cycle, model memory, and when each responder is free.
    logic       e_ready [2][NC];
    logic       e_rdv   [2][NC];
    logic       e_wd    [2][NC];
    logic       e_err   [2][NC];
    logic [7:0] e_data  [2][NC];
    logic [7:0] mm      [2][256];
    int         free_at [2];
    int         dep     [2] = '{256, 16};
    int         wsn     [2] = '{0, 2};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
        end
    endtask

    // Cycle counter: cycle k is the interval following the k-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (cyc < NC) begin
            for (int i = 0; i < 2; i++) begin
                chk("ready",    i, {7'b0, ready[i]},    {7'b0, e_ready[i][cyc]});
                chk("rd_valid", i, {7'b0, rd_valid[i]}, {7'b0, e_rdv[i][cyc]});
                chk("bus_oe",   i, {7'b0, bus_oe[i]},   {7'b0, e_rdv[i][cyc]});
                chk("bus_out",  i, bus_out[i],          e_data[i][cyc]);
                chk("wr_done",  i, {7'b0, wr_done[i]},  {7'b0, e_wd[i][cyc]});
                chk("err",      i, {7'b0, err[i]},      {7'b0, e_err[i][cyc]});
            end
        end
    end

    task automatic stp();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int i);
        while (cyc < free_at[i]) stp();
    endtask

    // Present a read request for one cycle; model records its outcome if accepted.
    task automatic rd(input int i, input logic [7:0] a);
        int k;
        int w;
        k = cyc;
        w = wsn[i];
        req_valid[i] = 1'b1;
        req_write[i] = 1'b0;
        bus_in[i]    = a;
        if (free_at[i] <= k) begin
            for (int c = k + 1; c <= k + 1 + w; c++) e_ready[i][c] = 1'b0;
            e_rdv[i][k+1+w]  = 1'b1;
            e_err[i][k+1+w]  = (int'(a) >= dep[i]);
            e_data[i][k+1+w] = (int'(a) >= dep[i]) ? 8'hFF : mm[i][a];
            free_at[i] = k + 2 + w;
        end
        stp();
        req_valid[i] = 1'b0;
        bus_in[i]    = 8'h00;
    endtask

    // Address cycle, then data cycle; optionally pulse reset during the data cycle.
    task automatic wr(input int i, input logic [7:0] a, input logic [7:0] d, input bit with_rst);
        int k;
        k = cyc;
        req_valid[i] = 1'b1;
        req_write[i] = 1'b1;
        bus_in[i]    = a;
        e_ready[i][k+1] = 1'b0;
        e_wd[i][k+2]    = 1'b1;
        e_err[i][k+2]   = (int'(a) >= dep[i]);
        stp();
        req_valid[i] = 1'b0;
        req_write[i] = 1'b0;
        bus_in[i]    = d;
        if (with_rst) begin
            rst[i] = 1'b1;
            e_ready[i][k+1] = 1'b1;
            e_wd[i][k+2]    = 1'b0;
            e_err[i][k+2]   = 1'b0;
            #1;
            chk("rst_ready",  i, {7'b0, ready[i]},  8'h01);
            chk("rst_bus_oe", i, {7'b0, bus_oe[i]}, 8'h00);
            chk("rst_bus_out", i, bus_out[i],       8'h00);
        end
        stp();
        bus_in[i] = 8'h00;
        if (with_rst) rst[i] = 1'b0;
        else if (int'(a) < dep[i]) mm[i][a] = d;
        free_at[i] = k + 2;
    endtask

    logic [7:0] pre [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NC; c++) begin
                e_ready[i][c] = 1'b1;
                e_rdv[i][c]   = 1'b0;
                e_wd[i][c]    = 1'b0;
                e_err[i][c]   = 1'b0;
                e_data[i][c]  = 8'h00;
            end
            for (int a = 0; a < 256; a++) mm[i][a] = 8'h00;
            rst[i] = 1'b1;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            bus_in[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        free_at[0] = cyc;
        free_at[1] = cyc;

        // Read of untouched word after reset returns the start-up value.
        rd(0, 8'h05);
        @(negedge clk);
        chk("init_read_data", 0, bus_out[0], 8'h00);
        chk("init_read_valid", 0, {7'b0, rd_valid[0]}, 8'h01);
        stp();
        chk("init_read_oe_drop", 0, {7'b0, bus_oe[0]}, 8'h00);

        // Write then read in the very next ready cycle.
        wait_idle(0);
        wr(0, 8'h10, 8'h3C, 1'b0);
        rd(0, 8'h10);
        @(negedge clk);
        chk("wr_rd_data", 0, bus_out[0], 8'h3C);
        stp();

        // Preload and stream reads of 0..7 back to back.
        for (int a = 0; a < 8; a++) begin
            wait_idle(0);
            wr(0, 8'(a), pre[a], 1'b0);
        end
        for (int a = 0; a < 8; a++) begin
            wait_idle(0);
            rd(0, 8'(a));
            if (a == 3) begin
                @(negedge clk);
                chk("stream_word3", 0, bus_out[0], 8'h78);
            end
        end

        // Reset during the data cycle cancels the write; reread is accepted right away.
        wait_idle(0);
        wr(0, 8'h01, 8'h55, 1'b1);
        rd(0, 8'h01);
        @(negedge clk);
        chk("rst_cancel_write", 0, bus_out[0], 8'h34);
        stp();

        // Wait-state read: busy for three cycles, extra request ignored.
        wait_idle(1);
        rd(1, 8'h10);
        req_valid[1] = 1'b1;
        bus_in[1]    = 8'h05;
        @(negedge clk);
        chk("ws_busy_ready", 1, {7'b0, ready[1]}, 8'h00);
        stp();
        req_valid[1] = 1'b0;
        bus_in[1]    = 8'h00;
        wait_idle(1);

        // Out-of-range write and read on the 16-word instance.
        wr(1, 8'h00, 8'h11, 1'b0);
        wr(1, 8'h05, 8'h5A, 1'b0);
        wr(1, 8'h20, 8'hAA, 1'b0);
        rd(1, 8'h20);
        stp();
        stp();
        @(negedge clk);
        chk("oor_read_data", 1, bus_out[1], 8'hFF);
        chk("oor_read_err", 1, {7'b0, err[1]}, 8'h01);
        stp();
        for (int a = 0; a < 16; a++) begin
            wait_idle(1);
            rd(1, 8'(a));
            if (a == 0) begin
                stp();
                stp();
                @(negedge clk);
                chk("word0_kept", 1, bus_out[1], 8'h11);
            end
        end
        wait_idle(1);
        repeat (3) stp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/unibus_memory.md
UNIBUS_MEMORY -- requirements
Module: unibus_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 8-bit words implemented, range 1..256.
REQ-002 SHALL have parameter WAIT_STATES, default 0: read wait cycles inserted before data, range 0..3.
REQ-003 SHALL have parameter INIT_VALUE, default 8'h00: simulation start-up content of every word.
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  initiator presents a request this cycle.
REQ-007 SHALL have port req_write  input  1  request type: 1 = WRITE, 0 = READ.
REQ-008 SHALL have port bus_in  input  8  unified-bus value driven by the initiator: address in the request cycle, write data in the data cycle.
REQ-009 SHALL have port bus_out  output  8  read data.
REQ-010 SHALL have port bus_oe  output  1  responder owns the unified bus; the top level forms the bus as bus_oe ? bus_out : 8'hZZ.
REQ-011 SHALL have port ready  output  1  a request is accepted this cycle if req_valid=1.
REQ-012 SHALL have port rd_valid  output  1  bus_out holds valid read data this cycle.
REQ-013 SHALL have port wr_done  output  1  one-cycle pulse: a write has been committed.
REQ-014 SHALL have port err  output  1  one-cycle pulse: the accepted address was >= DEPTH.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RDATA and WDATA, with the state register reset to IDLE.
REQ-016 SHALL assert ready only in IDLE; req_valid in any other state is ignored, not queued.
REQ-017 SHALL, in IDLE with req_valid=1, latch bus_in as the address and req_write as the command at the clock edge.
REQ-018 SHALL, on acceptance, go to WDATA if the command is WRITE, to RDATA if WAIT_STATES=0, otherwise to WAIT.
REQ-019 SHALL, in WAIT, count WAIT_STATES cycles with a 2-bit counter cleared at acceptance, then go to RDATA.
REQ-020 SHALL, in RDATA, drive bus_oe=1, rd_valid=1 and bus_out=mem[addr] for exactly one cycle, then go to IDLE.
REQ-021 SHALL give read latency as data valid in cycle N+1+WAIT_STATES for a request accepted in cycle N.
REQ-022 SHALL, in WDATA, sample bus_in and write it to mem[addr] at the end of that cycle, pulse wr_done in the following cycle, and go to IDLE.
REQ-023 SHALL keep bus_oe=0 in IDLE, WAIT and WDATA, and bus_out=8'h00 whenever rd_valid=0.
REQ-024 SHALL, for an address >= DEPTH, return 8'hFF on a read, suppress the array write on a write, and pulse err in the same cycle as rd_valid or wr_done.
REQ-025 SHALL make a read of an address return the value from the most recent completed write to it (back-to-back write-then-read included).
REQ-026 SHALL sustain one transaction every 2+WAIT_STATES cycles for reads and every 2 cycles for writes.

Reset
REQ-027 SHALL, on RST=1 at any time, immediately force state=IDLE, ready=1, bus_oe=0, bus_out=8'h00, rd_valid=0, wr_done=0, err=0, and clear the latched address, command and wait counter.
REQ-028 SHALL, when RST is asserted during WDATA, not perform the write; memory contents are never altered by RST.
REQ-029 SHALL accept a request in the first cycle after RST deasserts.

Structure
REQ-030 SHALL place the state enum, the READ/WRITE command constants and HIGH_IMPEDANCE in shared package unibus_pkg, which fetch also uses.
REQ-031 SHALL instantiate sub-module unibus_mem_array (DEPTH x 8, synchronous write, combinational read) for storage.
REQ-032 SHALL place no tristate inside the module; the tristate exists only at the top level.

Verification
REQ-033 SHALL cover: after reset with INIT_VALUE=8'h00, READ address 8'h05 -> rd_valid and bus_out=8'h00 one cycle later, bus_oe high for exactly that cycle.
REQ-034 SHALL cover: WRITE 8'h3C to 8'h10, then READ 8'h10 in the next cycle ready=1 -> wr_done pulse, then bus_out=8'h3C.
REQ-035 SHALL cover: WAIT_STATES=2, READ 8'h10 accepted at cycle N -> ready=0 in N+1..N+3, rd_valid only in N+3; req_valid in N+1 ignored.
REQ-036 SHALL cover: DEPTH=16, WRITE 8'hAA to 8'h20 then READ 8'h20 -> err pulsed both times, read returns 8'hFF, and words 8'h00..8'h0F are unchanged.
REQ-037 SHALL cover: RST pulsed during WDATA of a write of 8'h55 to 8'h01 -> all outputs at reset values immediately, and a later read of 8'h01 returns the old value.
REQ-038 SHALL cover: fetch-style stream of alternating READs to 8'h00..8'h07 with WAIT_STATES=0 -> one rd_valid every 2 cycles, data matching preloaded contents.
